mem_arbiter: RTL and testbench

- Shared-memory front end for the next-generation processor top.
- Arbitrates the instruction-fetch port and the data port onto one single-port word RAM with configurable read latency.
- Returns read data tagged back to the requester; instruction reads are extracted as 16-bit halfwords.
- Replaces the separate imem/dmem arrangement with one unified memory and adds stall/grant handshakes to the processor.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Unified instruction/data front end for a single-port word RAM: grant arbitration,
// RAM command steering and a tag pipeline that routes read data back to its requester.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int INST_W       = 16,
    parameter int RD_LATENCY   = 1,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [INST_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_W-3:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int         BE_W  = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [INST_W-1:0] pick_half(input logic [DATA_W-1:0] word,
                                                    input logic              hsel);
        if (hsel) begin
            pick_half = word[DATA_W-1:INST_W];
        end else begin
            pick_half = word[INST_W-1:0];
        end
    endfunction

    logic              i_win_s;
    logic [3:0]        starve_r;
    logic              last_fetch_r;
    // Tag bits: [2] fetch read, [1] data read, [0] halfword select
    logic [2:0]        new_tag_s;
    logic [2:0]        pre_tag_s;
    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic [INST_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              unused_s;

    // Decide whether fetch wins this cycle; data gets the grant otherwise
    always_comb begin
        i_win_s = 1'b0;
        if (!i_req) begin
            i_win_s = 1'b0;
        end else if (!d_req) begin
            i_win_s = 1'b1;
        end else if (ARB_MODE == 0) begin
            i_win_s = (starve_r >= LIMIT);
        end else begin
            i_win_s = !last_fetch_r;
        end
    end

    assign i_gnt     = resetn & i_win_s;
    assign d_gnt     = resetn & d_req & ~i_win_s;
    assign ram_en    = i_gnt | d_gnt;
    assign ram_wr    = d_gnt & d_we;
    assign ram_addr  = d_gnt ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
    assign ram_wdata = d_wdata;
    assign ram_be    = ram_wr ? d_be : {BE_W{1'b0}};
    assign new_tag_s = {i_gnt, d_gnt & ~d_we, i_addr[1]};
    assign unused_s  = ^{i_addr[0], d_addr[1:0]};

    // Starvation counter and last-winner history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_r     <= 4'd0;
            last_fetch_r <= 1'b0;
        end else begin
            if (i_gnt) begin
                starve_r <= 4'd0;
            end else if (i_req) begin
                starve_r <= starve_r + 4'd1;
            end else begin
                starve_r <= starve_r;
            end
            if (ram_en) begin
                last_fetch_r <= i_gnt;
            end else begin
                last_fetch_r <= last_fetch_r;
            end
        end
    end

    // The output registers are the final latency stage, so only RD_LATENCY-1 tag stages precede them
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign pre_tag_s = new_tag_s;
        end else begin : g_latn
            logic [2:0] tag_r [RD_LATENCY-1];

            // Shift read tags toward the output stage
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int j = 0; j < RD_LATENCY - 1; j++) begin
                        tag_r[j] <= 3'b000;
                    end
                end else begin
                    tag_r[0] <= new_tag_s;
                    for (int j = 1; j < RD_LATENCY - 1; j++) begin
                        tag_r[j] <= tag_r[j-1];
                    end
                end
            end

            assign pre_tag_s = tag_r[RD_LATENCY-2];
        end
    endgenerate

    // Capture returning RAM data for the requester named by the tail tag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_rdata_r  <= {INST_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            i_rvalid_r <= pre_tag_s[2];
            d_rvalid_r <= pre_tag_s[1];
            if (pre_tag_s[2]) begin
                i_rdata_r <= pick_half(ram_rdata, pre_tag_s[0]);
            end else begin
                i_rdata_r <= i_rdata_r;
            end
            if (pre_tag_s[1]) begin
                d_rdata_r <= ram_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign i_rvalid = i_rvalid_r;
    assign d_rvalid = d_rvalid_r;
    assign i_rdata  = i_rdata_r;
    assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (priority/L1, round-robin/L3,
// round-robin/L2) share one requester stimulus, each with its own RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;

    logic        i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a, ram_en_a, ram_wr_a;
    logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, ram_en_b, ram_wr_b;
    logic        i_gnt_c, i_rvalid_c, d_gnt_c, d_rvalid_c, ram_en_c, ram_wr_c;
    logic [15:0] i_rdata_a, i_rdata_b, i_rdata_c;
    logic [31:0] d_rdata_a, d_rdata_b, d_rdata_c;
    logic [31:0] ram_wdata_a, ram_wdata_b, ram_wdata_c;
    logic [31:0] ram_rdata_a, ram_rdata_b, ram_rdata_c;
    logic [13:0] ram_addr_a, ram_addr_b, ram_addr_c;
    logic [3:0]  ram_be_a, ram_be_b, ram_be_c;

    logic [31:0] mem_a [16384];
    logic [31:0] mem_b [16384];
    logic [31:0] mem_c [16384];
    logic [31:0] rd_b1, rd_b2, rd_c1;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(.RD_LATENCY(1), .ARB_MODE(0), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_a), .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .ram_en(ram_en_a), .ram_wr(ram_wr_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ram_be(ram_be_a), .ram_rdata(ram_rdata_a)
    );

    mem_arbiter #(.RD_LATENCY(3), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .ram_en(ram_en_b), .ram_wr(ram_wr_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ram_be(ram_be_b), .ram_rdata(ram_rdata_b)
    );

    mem_arbiter #(.RD_LATENCY(2), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_c (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_c), .i_rvalid(i_rvalid_c), .i_rdata(i_rdata_c),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt_c), .d_rvalid(d_rvalid_c), .d_rdata(d_rdata_c),
        .ram_en(ram_en_c), .ram_wr(ram_wr_c), .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c),
        .ram_be(ram_be_c), .ram_rdata(ram_rdata_c)
    );

    // RAM models: the arbiter's output register is the last latency stage,
    // so each model adds RD_LATENCY-1 register stages after an array read.
    assign ram_rdata_a = mem_a[ram_addr_a];
    assign ram_rdata_b = rd_b2;
    assign ram_rdata_c = rd_c1;

    always @(posedge clk) begin
        rd_b1 <= mem_b[ram_addr_b];
        rd_b2 <= rd_b1;
        rd_c1 <= mem_c[ram_addr_c];
        for (int k = 0; k < 4; k++) begin
            if (ram_en_a && ram_wr_a && ram_be_a[k]) mem_a[ram_addr_a][8*k +: 8] <= ram_wdata_a[8*k +: 8];
            if (ram_en_b && ram_wr_b && ram_be_b[k]) mem_b[ram_addr_b][8*k +: 8] <= ram_wdata_b[8*k +: 8];
            if (ram_en_c && ram_wr_c && ram_be_c[k]) mem_c[ram_addr_c][8*k +: 8] <= ram_wdata_c[8*k +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = addr;
        d_wdata = data;
        d_be    = be;
        settle();
        check_eq("wr_gnt_a", {29'd0, d_gnt_a, d_gnt_b, d_gnt_c}, 32'd7);
        tick();
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_i;
        resetn  = 1'b0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        i_addr  = 16'h0000;
        d_addr  = 16'h0000;
        d_wdata = 32'h0000_0000;
        d_be    = 4'h0;
        repeat (2) tick();
        settle();
        // Reset state: grants forced low even with both requests high
        check_eq("rst_i_gnt_a", i_gnt_a, 32'd0);
        check_eq("rst_d_gnt_a", d_gnt_a, 32'd0);
        check_eq("rst_ram_en_a", ram_en_a, 32'd0);
        check_eq("rst_i_gnt_b", i_gnt_b, 32'd0);
        check_eq("rst_d_gnt_c", d_gnt_c, 32'd0);
        check_eq("rst_i_rvalid_a", i_rvalid_a, 32'd0);
        check_eq("rst_d_rvalid_b", d_rvalid_b, 32'd0);
        check_eq("rst_i_rdata_c", i_rdata_c, 32'd0);
        check_eq("rst_d_rdata_b", d_rdata_b, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        write_word(16'h0000, 32'hBEEF_1234, 4'hF);
        write_word(16'h0010, 32'h5566_7788, 4'hF);
        write_word(16'h0014, 32'h1111_2222, 4'hF);
        repeat (4) tick();

        // Fetch only, latency 1, upper then lower halfword
        i_req  = 1'b1;
        i_addr = 16'h0002;
        settle();
        check_eq("t1_i_gnt", i_gnt_a, 32'd1);
        check_eq("t1_ram_en", ram_en_a, 32'd1);
        check_eq("t1_ram_addr", ram_addr_a, 32'd0);
        check_eq("t1_ram_be", ram_be_a, 32'd0);
        tick();
        check_eq("t1_i_rvalid_hi", i_rvalid_a, 32'd1);
        check_eq("t1_i_rdata_hi", i_rdata_a, 32'h0000_BEEF);
        i_addr = 16'h0000;
        settle();
        check_eq("t1_i_gnt2", i_gnt_a, 32'd1);
        tick();
        i_req = 1'b0;
        check_eq("t1_i_rvalid_lo", i_rvalid_a, 32'd1);
        check_eq("t1_i_rdata_lo", i_rdata_a, 32'h0000_1234);
        tick();
        check_eq("t1_i_rvalid_end", i_rvalid_a, 32'd0);
        check_eq("t1_i_rdata_hold", i_rdata_a, 32'h0000_1234);
        repeat (5) tick();

        // Partial write then read, latency 3
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_be    = 4'b0011;
        d_wdata = 32'hAABB_CCDD;
        settle();
        check_eq("t2_wr_gnt", d_gnt_b, 32'd1);
        check_eq("t2_wr_ram_wr", ram_wr_b, 32'd1);
        check_eq("t2_wr_ram_addr", ram_addr_b, 32'd4);
        check_eq("t2_wr_ram_be", ram_be_b, 32'h3);
        tick();
        d_we = 1'b0;
        settle();
        check_eq("t2_rd_gnt", d_gnt_b, 32'd1);
        check_eq("t2_rd_ram_wr", ram_wr_b, 32'd0);
        check_eq("t2_rd_ram_be", ram_be_b, 32'd0);
        tick();
        d_req = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            check_eq($sformatf("t2_d_rvalid_n%0d", n), d_rvalid_b, (n == 3) ? 32'd1 : 32'd0);
            if (n == 3) check_eq("t2_d_rdata", d_rdata_b, 32'h5566_CCDD);
            tick();
        end
        repeat (5) tick();

        // Continuous contention: priority+starvation (a) and round-robin (b)
        i_req  = 1'b1;
        i_addr = 16'h0000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0014;
        for (int c = 0; c < 10; c++) begin
            settle();
            exp_i = (c == 4) || (c == 9);
            check_eq($sformatf("t3_i_gnt_c%0d", c), i_gnt_a, {31'd0, exp_i});
            check_eq($sformatf("t3_d_gnt_c%0d", c), d_gnt_a, {31'd0, !exp_i});
            check_eq($sformatf("t4_i_gnt_c%0d", c), i_gnt_b, (c % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("t4_d_gnt_c%0d", c), d_gnt_b, (c % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) tick();

        // Pipelined I, D, I reads at latency 2
        i_req  = 1'b1;
        i_addr = 16'h0002;
        settle();
        check_eq("t5_gnt_i0", i_gnt_c, 32'd1);
        tick();
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_addr = 16'h0014;
        settle();
        check_eq("t5_gnt_d1", d_gnt_c, 32'd1);
        tick();
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0000;
        settle();
        check_eq("t5_gnt_i2", i_gnt_c, 32'd1);
        check_eq("t5_i_rvalid0", i_rvalid_c, 32'd1);
        check_eq("t5_i_rdata0", i_rdata_c, 32'h0000_BEEF);
        tick();
        i_req = 1'b0;
        check_eq("t5_d_rvalid1", d_rvalid_c, 32'd1);
        check_eq("t5_d_rdata1", d_rdata_c, 32'h1111_2222);
        check_eq("t5_i_rvalid_gap", i_rvalid_c, 32'd0);
        tick();
        check_eq("t5_i_rvalid2", i_rvalid_c, 32'd1);
        check_eq("t5_i_rdata2", i_rdata_c, 32'h0000_1234);
        check_eq("t5_d_rvalid_end", d_rvalid_c, 32'd0);
        tick();
        check_eq("t5_i_rvalid_end", i_rvalid_c, 32'd0);
        repeat (6) tick();

        // Reset one cycle after a latency-3 read grant
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0010;
        settle();
        check_eq("t6_rd_gnt", d_gnt_b, 32'd1);
        tick();
        i_req  = 1'b1;
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_d_rvalid", d_rvalid_b, 32'd0);
        check_eq("t6_rst_d_rdata", d_rdata_b, 32'd0);
        check_eq("t6_rst_i_rdata", i_rdata_b, 32'd0);
        check_eq("t6_rst_i_gnt", i_gnt_b, 32'd0);
        check_eq("t6_rst_d_gnt", d_gnt_b, 32'd0);
        check_eq("t6_rst_ram_en", ram_en_b, 32'd0);
        tick();
        i_req  = 1'b0;
        d_req  = 1'b0;
        resetn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            settle();
            check_eq($sformatf("t6_no_d_rvalid_%0d", n), d_rvalid_b, 32'd0);
            check_eq($sformatf("t6_no_i_rvalid_%0d", n), i_rvalid_b, 32'd0);
            tick();
        end
        i_req = 1'b1;
        d_req = 1'b1;
        settle();
        check_eq("t6_first_i_gnt", i_gnt_b, 32'd1);
        check_eq("t6_first_d_gnt", d_gnt_b, 32'd0);
        tick();
        settle();
        check_eq("t6_second_d_gnt", d_gnt_b, 32'd1);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
